// File: rtl/oled_page_streamer.sv
// Page-addressed SPI OLED streamer: panel reset, ROM init, dirty-page frames, then peripheral polling.
// Latency: 2 + 16*CLKS_PER_HALF_BIT cycles per byte (address, fetch, shift); memories read one cycle after address.
// Backpressure: none; i_Start is honoured only in IDLE and dropped otherwise.
module oled_page_streamer #(
    parameter int          COLS              = 128,
    parameter int          PAGES             = 8,
    parameter int          COL_OFFSET        = 0,
    parameter int          INIT_LEN          = 26,
    parameter int          CMD_AW            = 8,
    parameter int          CLKS_PER_HALF_BIT = 4,
    parameter int          RES_CYCLES        = 16,
    parameter int          N_POLL            = 1,
    parameter logic [7:0]  POLL_CMD          = 8'h00,
    parameter int          FRAME_GAP         = 0
) (
    input  logic                              i_Clk,
    input  logic                              i_Rst_L,
    input  logic                              i_Start,
    input  logic                              i_Continuous,
    input  logic [PAGES-1:0]                  i_Dirty,
    output logic [PAGES-1:0]                  o_Dirty_Clr,
    output logic [CMD_AW-1:0]                 o_Cmd_Addr,
    input  logic [7:0]                        i_Cmd_Byte,
    output logic [$clog2(COLS*PAGES)-1:0]     o_Fb_Addr,
    input  logic [7:0]                        i_Fb_Byte,
    output logic                              o_SPI_Clk,
    output logic                              o_SPI_MOSI,
    input  logic                              i_SPI_MISO,
    output logic                              o_DC,
    output logic                              o_RES,
    output logic                              o_CS_Disp,
    output logic [N_POLL-1:0]                 o_CS_Poll,
    output logic [7:0]                        o_Poll_Data,
    output logic [$clog2(N_POLL):0]           o_Poll_Chan,
    output logic                              o_Poll_Valid,
    output logic                              o_Busy,
    output logic                              o_Frame_Done
);
    localparam int PW  = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int HW  = $clog2(CLKS_PER_HALF_BIT + 1);
    localparam int CW  = $clog2(RES_CYCLES + FRAME_GAP + 2);
    localparam int IW  = $clog2(COLS + INIT_LEN + 4);
    localparam int FAW = $clog2(COLS * PAGES);
    localparam int CHW = $clog2(N_POLL) + 1;
    localparam logic [7:0] OFFS = 8'(COL_OFFSET);

    typedef enum logic [2:0] {S_RESET_HOLD, S_INIT, S_IDLE, S_PAGE_CMD, S_PAGE_DATA, S_POLL} state_t;
    typedef enum logic [1:0] {PH_ADDR, PH_FETCH, PH_SHIFT} phase_t;

    state_t             r_state;
    phase_t             r_phase;
    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_idx;
    logic [PW-1:0]      r_page;
    logic [PAGES-1:0]   r_pend;
    logic [CHW-1:0]     r_chan;
    logic [7:0]         r_shift, r_rx;
    logic [HW-1:0]      r_hcnt;
    logic [3:0]         r_half;
    logic [PAGES-1:0]   r_Dirty_Clr;
    logic [CMD_AW-1:0]  r_Cmd_Addr;
    logic [FAW-1:0]     r_Fb_Addr;
    logic               r_SPI_Clk, r_SPI_MOSI, r_DC, r_RES, r_CS_Disp;
    logic [N_POLL-1:0]  r_CS_Poll;
    logic [7:0]         r_Poll_Data;
    logic [CHW-1:0]     r_Poll_Chan;
    logic               r_Poll_Valid, r_Busy, r_Frame_Done;

    // Lowest set page in a mask; MSB flags that one was found.
    function automatic logic [PW:0] f_first(input logic [PAGES-1:0] m);
        logic [PW:0] r;
        r = '0;
        for (int i = PAGES - 1; i >= 0; i--)
            if (m[i]) r = {1'b1, PW'(i)};
        return r;
    endfunction

    logic [PAGES-1:0] w_hi;
    logic [PW:0]      w_hi_first, w_dirty_first;
    logic [7:0]       w_byte;
    logic             w_xfer, w_byte_done, w_gap_ok;

    always_comb begin
        w_hi = '0;
        for (int i = 0; i < PAGES; i++)
            if (i > int'(r_page)) w_hi[i] = r_pend[i];
        w_hi_first    = f_first(w_hi);
        w_dirty_first = f_first(i_Dirty);
        case (r_state)
            S_INIT:      w_byte = i_Cmd_Byte;
            S_PAGE_DATA: w_byte = i_Fb_Byte;
            S_PAGE_CMD: begin
                if (r_idx == IW'(0))      w_byte = 8'hB0 | 8'(r_page);
                else if (r_idx == IW'(1)) w_byte = {4'h0, OFFS[3:0]};
                else                      w_byte = {4'h1, OFFS[7:4]};
            end
            default:     w_byte = POLL_CMD;
        endcase
    end

    assign w_xfer      = (r_state == S_INIT) || (r_state == S_PAGE_CMD) ||
                         (r_state == S_PAGE_DATA) || (r_state == S_POLL);
    assign w_byte_done = (r_phase == PH_SHIFT) && (r_hcnt == HW'(CLKS_PER_HALF_BIT - 1)) && (r_half == 4'd15);
    assign w_gap_ok    = (int'(r_cnt) + 1) >= FRAME_GAP;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state <= S_RESET_HOLD;  r_phase <= PH_ADDR;     r_cnt <= '0;
            r_idx <= '0;  r_page <= '0;  r_pend <= '0;  r_chan <= '0;
            r_shift <= '0;  r_rx <= '0;  r_hcnt <= '0;  r_half <= '0;
            r_Dirty_Clr <= '0;  r_Cmd_Addr <= '0;  r_Fb_Addr <= '0;
            r_SPI_Clk <= 1'b0;  r_SPI_MOSI <= 1'b0;  r_DC <= 1'b0;  r_RES <= 1'b0;
            r_CS_Disp <= 1'b1;  r_CS_Poll <= '1;
            r_Poll_Data <= '0;  r_Poll_Chan <= '0;  r_Poll_Valid <= 1'b0;
            r_Busy <= 1'b1;  r_Frame_Done <= 1'b0;
        end else begin
            r_Dirty_Clr  <= '0;
            r_Poll_Valid <= 1'b0;
            r_Frame_Done <= 1'b0;

            // Shared byte engine; the state case below overrides r_phase when a byte completes.
            if (w_xfer) begin
                case (r_phase)
                    PH_ADDR:  r_phase <= PH_FETCH;
                    PH_FETCH: begin
                        r_shift    <= w_byte;
                        r_SPI_MOSI <= w_byte[7];
                        r_hcnt     <= '0;
                        r_half     <= '0;
                        r_phase    <= PH_SHIFT;
                    end
                    default: begin
                        if (r_hcnt == HW'(CLKS_PER_HALF_BIT - 1)) begin
                            r_hcnt <= '0;
                            r_half <= r_half + 4'd1;
                            if (!r_half[0]) begin
                                r_SPI_Clk <= 1'b1;
                                r_rx      <= {r_rx[6:0], i_SPI_MISO};
                            end else begin
                                r_SPI_Clk  <= 1'b0;
                                r_shift    <= {r_shift[6:0], 1'b0};
                                r_SPI_MOSI <= r_shift[6];
                            end
                        end else begin
                            r_hcnt <= r_hcnt + HW'(1);
                        end
                    end
                endcase
            end

            case (r_state)
                S_RESET_HOLD: begin
                    if (r_cnt == CW'(RES_CYCLES - 1)) begin
                        r_RES <= 1'b1;
                        r_cnt <= '0;
                        if (INIT_LEN > 0) begin
                            r_state <= S_INIT;  r_CS_Disp <= 1'b0;  r_DC <= 1'b0;
                            r_idx <= '0;  r_Cmd_Addr <= '0;  r_phase <= PH_ADDR;
                        end else begin
                            r_state <= S_IDLE;  r_Busy <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_INIT: if (w_byte_done) begin
                    r_phase <= PH_ADDR;
                    if (r_idx == IW'(INIT_LEN - 1)) begin
                        r_CS_Disp <= 1'b1;  r_state <= S_IDLE;  r_Busy <= 1'b0;  r_cnt <= '0;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                        r_Cmd_Addr <= r_Cmd_Addr + CMD_AW'(1);
                    end
                end
                S_IDLE: begin
                    if (i_Start || (i_Continuous && w_gap_ok)) begin
                        r_Busy <= 1'b1;  r_pend <= i_Dirty;  r_Dirty_Clr <= i_Dirty;
                        r_phase <= PH_ADDR;  r_idx <= '0;
                        if (w_dirty_first[PW]) begin
                            r_state <= S_PAGE_CMD;  r_page <= w_dirty_first[PW-1:0];
                            r_CS_Disp <= 1'b0;  r_DC <= 1'b0;
                        end else begin
                            r_state <= S_POLL;  r_chan <= '0;  r_CS_Poll <= ~N_POLL'(1);
                        end
                    end else if (r_cnt != {CW{1'b1}}) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_PAGE_CMD: if (w_byte_done) begin
                    r_phase <= PH_ADDR;
                    if (r_idx == IW'(2)) begin
                        r_state <= S_PAGE_DATA;  r_idx <= '0;  r_DC <= 1'b1;
                        r_Fb_Addr <= FAW'(r_page) * FAW'(COLS);
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_PAGE_DATA: if (w_byte_done) begin
                    r_phase <= PH_ADDR;
                    if (r_idx == IW'(COLS - 1)) begin
                        r_idx <= '0;  r_DC <= 1'b0;
                        if (w_hi_first[PW]) begin
                            r_state <= S_PAGE_CMD;  r_page <= w_hi_first[PW-1:0];
                        end else begin
                            r_CS_Disp <= 1'b1;  r_state <= S_POLL;
                            r_chan <= '0;  r_CS_Poll <= ~N_POLL'(1);
                        end
                    end else begin
                        r_idx <= r_idx + IW'(1);
                        r_Fb_Addr <= r_Fb_Addr + FAW'(1);
                    end
                end
                S_POLL: if (w_byte_done) begin
                    r_phase <= PH_ADDR;
                    r_CS_Poll <= '1;
                    r_Poll_Data <= r_rx;  r_Poll_Chan <= r_chan;  r_Poll_Valid <= 1'b1;
                    if (r_chan == CHW'(N_POLL - 1)) begin
                        r_state <= S_IDLE;  r_Frame_Done <= 1'b1;  r_Busy <= 1'b0;  r_cnt <= '0;
                    end else begin
                        r_chan <= r_chan + CHW'(1);
                        r_CS_Poll <= ~(N_POLL'(1) << (r_chan + CHW'(1)));
                    end
                end
                default: r_state <= S_RESET_HOLD;
            endcase
        end
    end

    assign o_Dirty_Clr  = r_Dirty_Clr;
    assign o_Cmd_Addr   = r_Cmd_Addr;
    assign o_Fb_Addr    = r_Fb_Addr;
    assign o_SPI_Clk    = r_SPI_Clk;
    assign o_SPI_MOSI   = r_SPI_MOSI;
    assign o_DC         = r_DC;
    assign o_RES        = r_RES;
    assign o_CS_Disp    = r_CS_Disp;
    assign o_CS_Poll    = r_CS_Poll;
    assign o_Poll_Data  = r_Poll_Data;
    assign o_Poll_Chan  = r_Poll_Chan;
    assign o_Poll_Valid = r_Poll_Valid;
    assign o_Busy       = r_Busy;
    assign o_Frame_Done = r_Frame_Done;
endmodule

// File: tb/tb_oled_page_streamer.sv
// Bench for oled_page_streamer: decodes the SPI pins into byte records and compares them
// against frames built from a table of dirty masks, plus reset, gap and start-ignore sequences.
module tb_oled_page_streamer;
    localparam int COLS = 128, PAGES = 8, COL_OFFSET = 2, INIT_LEN = 4, CMD_AW = 8;
    localparam int H = 2, RES_CYCLES = 16, N_POLL = 2, FRAME_GAP = 10;
    localparam logic [7:0] POLL_CMD = 8'h9F;
    localparam int BYTE_CYC = 16 * H + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, cont, miso;
    logic [7:0]  dirty, cmd_byte, fb_byte;
    logic [7:0]  dirty_clr, poll_data;
    logic [7:0]  cmd_addr;
    logic [9:0]  fb_addr;
    logic        sck, mosi, dc, res, cs_disp, poll_valid, busy, frame_done;
    logic [1:0]  cs_poll, poll_chan;

    oled_page_streamer #(
        .COLS(COLS), .PAGES(PAGES), .COL_OFFSET(COL_OFFSET), .INIT_LEN(INIT_LEN), .CMD_AW(CMD_AW),
        .CLKS_PER_HALF_BIT(H), .RES_CYCLES(RES_CYCLES), .N_POLL(N_POLL), .POLL_CMD(POLL_CMD),
        .FRAME_GAP(FRAME_GAP)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Continuous(cont), .i_Dirty(dirty),
        .o_Dirty_Clr(dirty_clr), .o_Cmd_Addr(cmd_addr), .i_Cmd_Byte(cmd_byte),
        .o_Fb_Addr(fb_addr), .i_Fb_Byte(fb_byte), .o_SPI_Clk(sck), .o_SPI_MOSI(mosi),
        .i_SPI_MISO(miso), .o_DC(dc), .o_RES(res), .o_CS_Disp(cs_disp), .o_CS_Poll(cs_poll),
        .o_Poll_Data(poll_data), .o_Poll_Chan(poll_chan), .o_Poll_Valid(poll_valid),
        .o_Busy(busy), .o_Frame_Done(frame_done)
    );

    function automatic logic [7:0] fb_val(input int a);
        return 8'((a * 37) ^ (a >> 7));
    endfunction

    logic [7:0] rom [0:255];
    always @(posedge clk) begin
        cmd_byte <= rom[cmd_addr];
        fb_byte  <= fb_val(int'(fb_addr));
    end

    // Monitor: SPI byte decoder, MISO slave, strobe capture.
    typedef struct { logic [7:0] b; logic dc; logic disp; logic [1:0] poll; int t; int fa; } rec_t;
    rec_t       q[$];
    logic [7:0] pd[$];
    int         pc[$];
    int         cyc = 0, bitcnt = 0, t_first = 0, cs_viol = 0;
    int         frame_done_cnt = 0, frame_done_cyc = 0, busy_rise_cyc = 0, clr_cycles = 0;
    logic [7:0] sh = '0, clr_val = '0, poll_tx0 = '0, poll_tx1 = '0;
    logic       prev_sck = 1'b0, prev_busy = 1'b0;
    logic [2:0] bi;

    assign bi   = 3'(7 - bitcnt);
    assign miso = !cs_poll[0] ? poll_tx0[bi] : (!cs_poll[1] ? poll_tx1[bi] : 1'b0);

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sck && !prev_sck) begin
            if (bitcnt == 0) t_first = cyc;
            sh = {sh[6:0], mosi};
            bitcnt++;
            if (bitcnt == 8) begin
                q.push_back('{b: sh, dc: dc, disp: cs_disp, poll: cs_poll, t: t_first, fa: int'(fb_addr)});
                bitcnt = 0;
            end
        end
        if (cs_disp && (&cs_poll)) bitcnt = 0;
        prev_sck = sck;
        if ($countones({~cs_disp, ~cs_poll}) > 1) cs_viol++;
        if (poll_valid) begin pd.push_back(poll_data); pc.push_back(int'(poll_chan)); end
        if (dirty_clr != 8'h00) begin clr_val = dirty_clr; clr_cycles++; end
        if (frame_done) begin frame_done_cnt++; frame_done_cyc = cyc; end
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        prev_busy = busy;
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] key(input rec_t r);
        return {r.b, r.disp ? 1'b0 : r.dc, r.disp, r.poll};
    endfunction

    task automatic do_reset(input string tag);
        int n;
        rst_n = 1'b0;
        tick(1);
        check({tag, "_reset_state"},
              {res, cs_disp, cs_poll, sck, mosi, dc, poll_valid, poll_data, poll_chan, frame_done, dirty_clr, busy},
              {1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 1'b1});
        q.delete();
        rst_n = 1'b1;
        n = 0;
        while (!res && n < 200) begin n++; tick(1); end
        check({tag, "_res_low_cycles"}, n, RES_CYCLES);
    endtask

    task automatic check_init(input string tag);
        int n;
        logic [7:0] exp_init [4];
        exp_init = '{8'hAE, 8'hD5, 8'h80, 8'hAF};
        n = 0;
        while (busy && n < 2000) begin n++; tick(1); end
        check({tag, "_init_idle"}, busy, 1'b0);
        check({tag, "_init_count"}, q.size(), INIT_LEN);
        for (int i = 0; i < INIT_LEN && i < q.size(); i++)
            check($sformatf("%s_init_byte%0d", tag, i), {q[i].b, q[i].dc, q[i].disp, q[i].poll},
                  {exp_init[i], 1'b0, 1'b0, 2'b11});
        if (q.size() >= 2) check({tag, "_byte_spacing"}, q[1].t - q[0].t, BYTE_CYC);
    endtask

    typedef struct {
        logic [7:0] dirty, miso0, miso1, exp_clr, exp_cmd0;
        int exp_nbytes, exp_clr_cycles, exp_fa_first, exp_fa_last;
    } vec_t;
    vec_t vec [4];

    initial begin
        rec_t exp_q[$];
        int n, fd0, mism, fa_f, fa_l, t_fd, busy_cnt, dcnt;

        vec[0] = '{dirty: 8'h05, miso0: 8'h41, miso1: 8'h00, exp_clr: 8'h05, exp_cmd0: 8'hB0,
                   exp_nbytes: 262, exp_clr_cycles: 1, exp_fa_first: 0,   exp_fa_last: 383};
        vec[1] = '{dirty: 8'h80, miso0: 8'hA5, miso1: 8'h3C, exp_clr: 8'h80, exp_cmd0: 8'hB7,
                   exp_nbytes: 131, exp_clr_cycles: 1, exp_fa_first: 896, exp_fa_last: 1023};
        vec[2] = '{dirty: 8'h00, miso0: 8'h41, miso1: 8'h00, exp_clr: 8'h00, exp_cmd0: 8'h9F,
                   exp_nbytes: 0,   exp_clr_cycles: 0, exp_fa_first: -1,  exp_fa_last: -1};
        vec[3] = '{dirty: 8'h42, miso0: 8'h00, miso1: 8'hFF, exp_clr: 8'h42, exp_cmd0: 8'hB1,
                   exp_nbytes: 262, exp_clr_cycles: 1, exp_fa_first: 128, exp_fa_last: 895};

        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = 8'hAE; rom[1] = 8'hD5; rom[2] = 8'h80; rom[3] = 8'hAF;
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; dirty = 8'h00;
        #1;

        do_reset("boot");
        check_init("boot");

        for (int i = 0; i < 4; i++) begin
            q.delete(); pd.delete(); pc.delete();
            clr_val = 8'h00; clr_cycles = 0; fd0 = frame_done_cnt;
            poll_tx0 = vec[i].miso0; poll_tx1 = vec[i].miso1;
            dirty = vec[i].dirty; start = 1'b1;
            tick(1);
            start = 1'b0; dirty = 8'h00;
            n = 0;
            while (frame_done_cnt == fd0 && n < 20000) begin n++; tick(1); end
            check($sformatf("v%0d_frame_done", i), frame_done_cnt - fd0, 1);

            exp_q.delete();
            for (int p = 0; p < PAGES; p++) begin
                if (vec[i].dirty[p]) begin
                    exp_q.push_back('{b: 8'hB0 | 8'(p), dc: 1'b0, disp: 1'b0, poll: 2'b11, t: 0, fa: 0});
                    exp_q.push_back('{b: 8'(COL_OFFSET % 16), dc: 1'b0, disp: 1'b0, poll: 2'b11, t: 0, fa: 0});
                    exp_q.push_back('{b: 8'h10 | 8'(COL_OFFSET / 16), dc: 1'b0, disp: 1'b0, poll: 2'b11, t: 0, fa: 0});
                    for (int c = 0; c < COLS; c++)
                        exp_q.push_back('{b: fb_val(p * COLS + c), dc: 1'b1, disp: 1'b0, poll: 2'b11, t: 0, fa: 0});
                end
            end
            exp_q.push_back('{b: POLL_CMD, dc: 1'b0, disp: 1'b1, poll: 2'b10, t: 0, fa: 0});
            exp_q.push_back('{b: POLL_CMD, dc: 1'b0, disp: 1'b1, poll: 2'b01, t: 0, fa: 0});

            check($sformatf("v%0d_stream_len", i), q.size(), vec[i].exp_nbytes + 2);
            if (q.size() > 0) check($sformatf("v%0d_first_byte", i), q[0].b, vec[i].exp_cmd0);
            mism = 0;
            for (int k = 0; k < q.size() && k < exp_q.size(); k++)
                if (key(q[k]) !== key(exp_q[k])) mism++;
            check($sformatf("v%0d_stream_mismatches", i), mism, 0);

            fa_f = -1; fa_l = -1;
            foreach (q[k]) if (q[k].dc && !q[k].disp) begin
                if (fa_f < 0) fa_f = q[k].fa;
                fa_l = q[k].fa;
            end
            if (vec[i].exp_fa_first >= 0) begin
                check($sformatf("v%0d_first_fb_addr", i), fa_f, vec[i].exp_fa_first);
                check($sformatf("v%0d_last_fb_addr", i), fa_l, vec[i].exp_fa_last);
            end
            check($sformatf("v%0d_dirty_clr", i), clr_val, vec[i].exp_clr);
            check($sformatf("v%0d_dirty_clr_width", i), clr_cycles, vec[i].exp_clr_cycles);
            check($sformatf("v%0d_poll_count", i), pd.size(), 2);
            if (pd.size() == 2)
                check($sformatf("v%0d_poll_results", i), {pd[0], 8'(pc[0]), pd[1], 8'(pc[1])},
                      {vec[i].miso0, 8'd0, vec[i].miso1, 8'd1});
        end

        // Continuous mode: gap after Frame_Done, and a mid-frame start must not queue a frame.
        fd0 = frame_done_cnt;
        cont = 1'b1;
        n = 0;
        while (frame_done_cnt == fd0 && n < 2000) begin n++; tick(1); end
        check("cont_first_frame", frame_done_cnt - fd0, 1);
        t_fd = frame_done_cyc;
        n = 0;
        while (busy_rise_cyc <= t_fd && n < 200) begin n++; tick(1); end
        check("cont_frame_gap", busy_rise_cyc - t_fd, FRAME_GAP);
        tick(20);
        check("cont_busy_mid_frame", busy, 1'b1);
        start = 1'b1;
        tick(1);
        start = 1'b0; cont = 1'b0;
        n = 0;
        while (frame_done_cnt < fd0 + 2 && n < 2000) begin n++; tick(1); end
        check("cont_second_frame", frame_done_cnt - fd0, 2);
        busy_cnt = 0;
        for (int k = 0; k < 60; k++) begin tick(1); if (busy) busy_cnt++; end
        check("start_ignored_busy_cycles", busy_cnt, 0);

        // Reset in the middle of page data.
        q.delete();
        dirty = 8'h01; start = 1'b1;
        tick(1);
        start = 1'b0; dirty = 8'h00;
        n = 0; dcnt = 0;
        while (dcnt < 5 && n < 2000) begin
            n++; tick(1);
            dcnt = 0;
            foreach (q[k]) if (q[k].dc && !q[k].disp) dcnt++;
        end
        check("midreset_data_started", dcnt >= 5, 1'b1);
        tick(7);
        do_reset("midreset");
        check_init("midreset");

        check("single_cs_low", cs_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
